// File: rtl/frame_sync_receiver.sv
// Frame sync receiver: hunts for SYNC1/SYNC2 in a serial MSB-first bit stream, locks word
// alignment and deserializes num_word 16-bit data words per frame.
// Optional build macro DATA_CHECK_EN enables the incrementing-sequence checker that drives
// count_error / error_count; without it both outputs are tied to zero.
module frame_sync_receiver #(
   parameter logic [15:0] SYNC1      = 16'hFE6B,
   parameter logic [15:0] SYNC2      = 16'h2840,
   parameter int unsigned MISS_LIMIT = 2
) (
   input  logic        clock_in,
   input  logic        reset,
   input  logic        data_in,
   input  logic [15:0] num_word,
   output logic [15:0] word_out,
   output logic        word_valid,
   output logic        frame_start,
   output logic        locked,
   output logic        sync_miss,
   output logic        count_error,
   output logic [15:0] error_count
);

   localparam logic [3:0] MISS_MAX = 4'(MISS_LIMIT);

   typedef enum logic [2:0] {SEARCH, CHECK2, DATA, SYNC_A, SYNC_B} state_t;

   state_t      state;
   logic [15:0] sr;
   logic [3:0]  bc;
   logic [15:0] wc;
   logic [15:0] last_idx;   // index of the final data word in the current frame
   logic [3:0]  miss;
   logic        match1;

   logic [15:0] word;
   logic        boundary;
   logic [15:0] num_last;

   // Value the shift register takes on this edge; all comparisons use it.
   assign word     = {sr[14:0], data_in};
   assign boundary = (bc == 4'd15);
   assign num_last = (num_word == 16'd0) ? 16'd0 : num_word - 16'd1;

   // Sync hunting, lock tracking and word deserialization FSM with registered outputs.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         state       <= SEARCH;
         sr          <= '0;
         bc          <= '0;
         wc          <= '0;
         last_idx    <= '0;
         miss        <= '0;
         match1      <= 1'b0;
         word_out    <= '0;
         word_valid  <= 1'b0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         sync_miss   <= 1'b0;
      end else begin
         sr          <= word;
         word_valid  <= 1'b0;
         frame_start <= 1'b0;
         sync_miss   <= 1'b0;
         if (state != SEARCH) begin
            bc <= bc + 4'd1;
         end
         case (state)
            SEARCH: begin
               if (word == SYNC1) begin
                  state <= CHECK2;
                  bc    <= '0;
               end
            end
            CHECK2: begin
               if (boundary) begin
                  if (word == SYNC2) begin
                     state    <= DATA;
                     wc       <= '0;
                     miss     <= '0;
                     locked   <= 1'b1;
                     last_idx <= num_last;
                  end else begin
                     state <= SEARCH;
                  end
               end
            end
            DATA: begin
               if (boundary) begin
                  word_out    <= word;
                  word_valid  <= 1'b1;
                  frame_start <= (wc == 16'd0);
                  if (wc == last_idx) begin
                     state <= SYNC_A;
                     wc    <= '0;
                  end else begin
                     wc <= wc + 16'd1;
                  end
               end
            end
            SYNC_A: begin
               if (boundary) begin
                  match1 <= (word == SYNC1);
                  state  <= SYNC_B;
               end
            end
            SYNC_B: begin
               if (boundary) begin
                  if (match1 && (word == SYNC2)) begin
                     miss     <= '0;
                     state    <= DATA;
                     wc       <= '0;
                     last_idx <= num_last;
                  end else begin
                     sync_miss <= 1'b1;
                     if (miss + 4'd1 >= MISS_MAX) begin
                        miss   <= '0;
                        state  <= SEARCH;
                        locked <= 1'b0;
                     end else begin
                        // Flywheel: keep alignment and carry on with the next frame.
                        miss     <= miss + 4'd1;
                        state    <= DATA;
                        wc       <= '0;
                        last_idx <= num_last;
                     end
                  end
               end
            end
            default: state <= SEARCH;
         endcase
      end
   end

`ifdef DATA_CHECK_EN
   logic [15:0] prev_word;
   logic        armed;      // low until the first word after acquisition seeds prev_word
   logic        data_edge;
   logic        lock_edge;

   assign data_edge = (state == DATA) && boundary;
   assign lock_edge = (state == CHECK2) && boundary && (word == SYNC2);

   // Check every delivered word against the previous word plus one.
   always_ff @(posedge clock_in) begin
      if (reset) begin
         prev_word   <= '0;
         armed       <= 1'b0;
         count_error <= 1'b0;
         error_count <= '0;
      end else begin
         count_error <= 1'b0;
         if (lock_edge) begin
            armed <= 1'b0;
         end else if (data_edge) begin
            if (armed && (word != prev_word + 16'd1)) begin
               count_error <= 1'b1;
               if (error_count != 16'hFFFF) begin
                  error_count <= error_count + 16'd1;
               end
            end
            prev_word <= word;
            armed     <= 1'b1;
         end
      end
   end
`else
   assign count_error = 1'b0;
   assign error_count = 16'h0000;
`endif

endmodule
